iso_path_array: RTL and testbench

ISO_PATH_ARRAY -- requirements
Module: iso_path_array

---
 rtl/iso_path_pkg.sv | 14 +
 rtl/iso_path_lane.sv | 69 ++++++
 rtl/iso_path_array.sv | 104 ++++++++++
 tb/tb_iso_path_array.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iso_path_pkg.sv
// Shared lane-mode type and default sizing for the iso_path_array block.
package iso_path_pkg;

    typedef enum logic {
        NORMAL   = 1'b0,
        INVERTED = 1'b1
    } lane_mode_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_N_CH  = 2;
    localparam int DEF_DEPTH = 2;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/iso_path_lane.sv
// One path channel: first-stage logic, DEPTH delay stages, post-stage logic, output register.
// Latency: DEPTH+1 edges from i_adv acceptance to o_res.
// Backpressure: everything holds while i_adv is low; o_res reloads only on i_out_load.
module iso_path_lane
    import iso_path_pkg::*;
#(
    parameter int         WIDTH = DEF_WIDTH,
    parameter int         DEPTH = DEF_DEPTH,
    parameter lane_mode_e MODE  = NORMAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_adv,
    input  logic             i_out_load,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_res
);

    logic [WIDTH-1:0] r_q [DEPTH];
    logic [WIDTH-1:0] r_a [DEPTH];
    logic [WIDTH-1:0] r_b [DEPTH];
    logic [WIDTH-1:0] r_res;

    logic [WIDTH-1:0] w_bx_in;
    logic [WIDTH-1:0] w_t0;
    logic [WIDTH-1:0] w_t1;
    logic [WIDTH-1:0] w_t2;
    logic [WIDTH-1:0] w_bx_out;
    logic [WIDTH-1:0] w_t3;
    logic [WIDTH-1:0] w_t4;

    assign w_bx_in = (MODE == INVERTED) ? ~i_b : i_b;
    assign w_t0    = i_a ^ w_bx_in;
    assign w_t1    = w_t0 & i_a;
    assign w_t2    = w_t1 | i_b;

    // Post-stage logic sees only the delayed operands, never the live inputs.
    assign w_bx_out = (MODE == INVERTED) ? ~r_b[DEPTH-1] : r_b[DEPTH-1];
    assign w_t3     = (MODE == INVERTED) ? (r_q[DEPTH-1] & r_a[DEPTH-1])
                                         : (r_q[DEPTH-1] & ~r_a[DEPTH-1]);
    assign w_t4     = w_t3 ^ w_bx_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_q[k] <= '0;
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
            r_res <= '0;
        end else if (i_adv) begin
            r_q[0] <= w_t2;
            r_a[0] <= i_a;
            r_b[0] <= i_b;
            for (int k = 1; k < DEPTH; k++) begin
                r_q[k] <= r_q[k-1];
                r_a[k] <= r_a[k-1];
                r_b[k] <= r_b[k-1];
            end
            if (i_out_load) begin
                r_res <= w_t4;
            end
        end
    end

    assign o_res = r_res;

endmodule

// File: rtl/iso_path_array.sv
// N_CH parallel iso-path channels with shared handshake; mismatch counter under ISO_MISMATCH_CNT_EN.
// Latency: DEPTH+1 edges from input acceptance to out_valid.
// Backpressure: single global enable; in_ready drops and all stages hold while out_valid && !out_ready.
module iso_path_array
    import iso_path_pkg::*;
#(
    parameter int              WIDTH    = DEF_WIDTH,
    parameter int              N_CH     = DEF_N_CH,
    parameter int              DEPTH    = DEF_DEPTH,
    parameter logic [N_CH-1:0] INV_MASK = '0,
    parameter int              CNT_W    = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_a,
    input  logic [WIDTH-1:0]      in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_CH*WIDTH-1:0] out_data,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      mismatch_cnt,
    output logic                  mismatch_sticky
);

    logic [DEPTH-1:0] r_vld;
    logic             r_out_vld;
    logic             w_en;

    assign w_en      = !r_out_vld || out_ready;
    assign in_ready  = w_en && !rst;
    assign out_valid = r_out_vld;

    // Bubbles travel as cleared valid bits so the stage spacing is preserved.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld     <= '0;
            r_out_vld <= 1'b0;
        end else if (w_en) begin
            r_vld[0] <= in_valid;
            for (int k = 1; k < DEPTH; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
            r_out_vld <= r_vld[DEPTH-1];
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        iso_path_lane #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .MODE  (INV_MASK[c] ? INVERTED : NORMAL)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .i_adv      (w_en),
            .i_out_load (r_vld[DEPTH-1]),
            .i_a        (in_a),
            .i_b        (in_b),
            .o_res      (out_data[c*WIDTH +: WIDTH])
        );
    end

`ifdef ISO_MISMATCH_CNT_EN
    logic             w_diff;
    logic             w_hs;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sticky;

    always_comb begin
        w_diff = 1'b0;
        for (int c = 1; c < N_CH; c++) begin
            if (out_data[c*WIDTH +: WIDTH] != out_data[WIDTH-1:0]) begin
                w_diff = 1'b1;
            end
        end
    end

    assign w_hs = r_out_vld && out_ready;

    // Clear wins over a same-cycle mismatch; the count saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_cnt    <= '0;
            r_sticky <= 1'b0;
        end else if (w_hs && w_diff) begin
            if (r_cnt != {CNT_W{1'b1}}) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_sticky <= 1'b1;
        end
    end

    assign mismatch_cnt    = r_cnt;
    assign mismatch_sticky = r_sticky;
`else
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = cnt_clr;
    assign mismatch_cnt     = '0;
    assign mismatch_sticky  = 1'b0;
`endif

endmodule

// File: tb/tb_iso_path_array.sv
// Scoreboard bench for iso_path_array (WIDTH 8, two channels, channel 1 inverted, 2-bit counter).
module tb_iso_path_array;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        cnt_clr;
    logic [1:0]  mismatch_cnt;
    logic        mismatch_sticky;

    int          n_total = 0;
    int          n_fail  = 0;
    bit          last_acc = 1'b0;
    logic [15:0] exp_q[$];
    int          m_cnt    = 0;
    int          m_sticky = 0;

`ifdef ISO_MISMATCH_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    iso_path_array #(
        .WIDTH    (8),
        .N_CH     (2),
        .DEPTH    (2),
        .INV_MASK (2'b10),
        .CNT_W    (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_a            (in_a),
        .in_b            (in_b),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .cnt_clr         (cnt_clr),
        .mismatch_cnt    (mismatch_cnt),
        .mismatch_sticky (mismatch_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reduced closed forms: normal lane = a & b, inverted lane = a | ~b.
    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
        return {a | ~b, a & b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_total++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic tick();
        bit acc;
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        last_acc = acc;
    endtask

    task automatic send_one(input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_acc) break;
        end
        if (!last_acc) fail_now("send_timeout");
        in_valid = 1'b0;
    endtask

    // Input side: every accepted pair pushes its expected result.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            exp_q.push_back(model(in_a, in_b));
        end
    end

    // Output side: compare presented data and counters against the model.
    always @(negedge clk) begin
        logic [15:0] e;
        bit          hs;
        bit          diff;
        if (rst) begin
            exp_q.delete();
            m_cnt    = 0;
            m_sticky = 0;
        end else begin
            check("mismatch_cnt", 32'(mismatch_cnt), 32'(m_cnt));
            check("mismatch_sticky", 32'(mismatch_sticky), 32'(m_sticky));
            hs   = 1'b0;
            diff = 1'b0;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("spurious_out_valid");
                end else begin
                    check("out_data", 32'(out_data), 32'(exp_q[0]));
                    if (out_ready) begin
                        e    = exp_q.pop_front();
                        hs   = 1'b1;
                        diff = (e[15:8] != e[7:0]);
                    end
                end
            end
            if (CNT_ON) begin
                if (cnt_clr) begin
                    m_cnt    = 0;
                    m_sticky = 0;
                end else if (hs && diff) begin
                    if (m_cnt != 3) m_cnt++;
                    m_sticky = 1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("in_ready_in_reset", 32'(in_ready), 32'd0);
        end
        rst = 1'b0;
        tick();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_cnt", 32'(mismatch_cnt), 32'd0);

        // Single pair latency: accept edge counts as edge 1, out_valid after edge 3.
        in_valid = 1'b1;
        in_a     = 8'h00;
        in_b     = 8'hFF;
        tick();
        check("lat_accept", 32'(last_acc), 32'd1);
        in_valid = 1'b0;
        check("lat_edge1", 32'(out_valid), 32'd0);
        tick();
        check("lat_edge2", 32'(out_valid), 32'd0);
        tick();
        check("lat_edge3", 32'(out_valid), 32'd1);
        check("lat_data", 32'(out_data), 32'h0000);
        tick();

        send_one(8'hFF, 8'h00);
        repeat (5) tick();
        check("first_mismatch_cnt", 32'(mismatch_cnt), CNT_ON ? 32'd1 : 32'd0);
        check("first_mismatch_sticky", 32'(mismatch_sticky), CNT_ON ? 32'd1 : 32'd0);

        // Stall: pipeline fills, in_ready drops, data held, then released.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 8'($urandom);
        in_b      = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (last_acc) begin
                in_a = 8'($urandom);
                in_b = 8'($urandom);
            end
            if (i >= 3) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_out_valid", 32'(out_valid), 32'd1);
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (last_acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check("stall_drained", 32'(exp_q.size()), 32'd0);

        // Saturation at 3 with five mismatching results.
        for (int i = 0; i < 5; i++) send_one(8'hFF, 8'h00);
        repeat (5) tick();
        check("sat_cnt", 32'(mismatch_cnt), CNT_ON ? 32'd3 : 32'd0);

        // Clear coinciding with a mismatching handshake.
        send_one(8'hFF, 8'h00);
        for (int i = 0; i < 10 && !out_valid; i++) tick();
        if (!out_valid) fail_now("clr_wait_timeout");
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_cnt", 32'(mismatch_cnt), 32'd0);
        check("clr_sticky", 32'(mismatch_sticky), 32'd0);

        // Randomized traffic with random backpressure and occasional clears.
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_a     = 8'($urandom);
                in_b     = 8'($urandom);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            cnt_clr   = ($urandom_range(0, 19) == 0);
            tick();
        end
        in_valid  = 1'b0;
        cnt_clr   = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("random_drained", 32'(exp_q.size()), 32'd0);

        // Reset with two pairs in flight: neither may emerge.
        send_one(8'($urandom), 8'($urandom));
        send_one(8'($urandom), 8'($urandom));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_reset_out_valid", 32'(out_valid), 32'd0);
        end
        check("post_reset_cnt", 32'(mismatch_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
